// File: rtl/system_led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, PIO offsets,
// step operation codes and sequencer state encoding.
package system_led_seq_pkg;

    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_STATUS    = 4'd1;
    localparam logic [3:0] REG_LENGTH    = 4'd2;
    localparam logic [3:0] REG_STEP_BASE = 4'd8;

    localparam logic [2:0] PIO_DATA  = 3'd0;
    localparam logic [2:0] PIO_SET   = 3'd4;
    localparam logic [2:0] PIO_CLEAR = 3'd5;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'b00,
        OP_SET       = 2'b01,
        OP_CLEAR     = 2'b10,
        OP_WRITE_ALT = 2'b11
    } step_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DWELL,
        ST_ADVANCE
    } seq_state_e;

    // The reserved op code falls through to a plain data write.
    function automatic logic [2:0] pio_offset(input logic [1:0] op);
        case (op)
            OP_SET:   return PIO_SET;
            OP_CLEAR: return PIO_CLEAR;
            default:  return PIO_DATA;
        endcase
    endfunction

endpackage

// File: rtl/system_led_seq_tick.sv
// Dwell prescaler: emits a one-cycle tick every PRESCALE cycles, counted from
// the last cycle in which restart was high.
module system_led_seq_tick #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= RELOAD;
        end else if (restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/system_led_sequencer.sv
// Autonomous LED pattern sequencer: CPU-loaded step table replayed as Avalon-MM
// writes to the LED PIO with a programmable dwell between steps.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for RUN; master idle
//   ST_ISSUE   | PIO write held on the master port until waitrequest drops
//   ST_DWELL   | counting prescaler ticks for the step's dwell
//   ST_ADVANCE | pick next step, wrap on LOOP, or finish and flag DONE
module system_led_sequencer
    import system_led_seq_pkg::*;
#(
    parameter int LED_WIDTH = 7,
    parameter int DEPTH     = 8,
    parameter int PRESCALE  = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [31:0] PAT_MASK  = 32'((64'd1 << LED_WIDTH) - 64'd1);
    localparam logic [31:0] STEP_MASK = 32'hFFFF_0300 | PAT_MASK;

    seq_state_e       state;
    logic [31:0]      steps [DEPTH];
    logic             run;
    logic             loop_en;
    logic             done;
    logic [3:0]       length;
    logic [IDX_W-1:0] index;
    logic [15:0]      dwell_cnt;

    logic             slave_wr;
    logic [3:0]       len_eff;
    logic             last_step;
    logic [IDX_W-1:0] next_idx;
    logic [31:0]      next_step;
    logic             tick;
    logic             tick_restart;

    assign slave_wr  = s_chipselect && !s_write_n;
    assign len_eff   = (length > 4'(DEPTH)) ? 4'(DEPTH) : length;
    // Written as ">=" so a LENGTH shrunk mid-run below the current index still ends the pass.
    assign last_step = (4'(index) + 4'd1) >= len_eff;
    assign next_idx  = (state == ST_ADVANCE && !last_step) ? index + 1'b1 : '0;
    assign next_step = steps[next_idx];
    assign tick_restart = (state != ST_DWELL);

    system_led_seq_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (tick_restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) steps[i] <= '0;
        end else if (slave_wr && s_address >= REG_STEP_BASE) begin
            steps[s_address[IDX_W-1:0]] <= s_writedata & STEP_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            index        <= '0;
            run          <= 1'b0;
            loop_en      <= 1'b0;
            done         <= 1'b0;
            length       <= '0;
            dwell_cnt    <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= '0;
            m_writedata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        index <= '0;
                        if (len_eff == 4'd0) begin
                            run  <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            state        <= ST_ISSUE;
                            m_chipselect <= 1'b1;
                            m_write_n    <= 1'b0;
                            m_address    <= pio_offset(next_step[9:8]);
                            m_writedata  <= next_step & PAT_MASK;
                            dwell_cnt    <= next_step[31:16];
                        end
                    end
                end
                ST_ISSUE: begin
                    // An accepted transfer is never abandoned; a RUN drop only takes effect after it.
                    if (!m_waitrequest) begin
                        m_chipselect <= 1'b0;
                        m_write_n    <= 1'b1;
                        m_address    <= '0;
                        m_writedata  <= '0;
                        state        <= run ? ST_DWELL : ST_IDLE;
                    end
                end
                ST_DWELL: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (dwell_cnt == 16'd0) begin
                        state <= ST_ADVANCE;
                    end else if (tick) begin
                        if (dwell_cnt == 16'd1) state <= ST_ADVANCE;
                        else dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (last_step && !loop_en) begin
                        run   <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        index        <= next_idx;
                        state        <= ST_ISSUE;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= pio_offset(next_step[9:8]);
                        m_writedata  <= next_step & PAT_MASK;
                        dwell_cnt    <= next_step[31:16];
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // CPU writes land after the FSM so a same-cycle CTRL write wins.
            if (slave_wr) begin
                case (s_address)
                    REG_CTRL: begin
                        run     <= s_writedata[0];
                        loop_en <= s_writedata[1];
                        done    <= 1'b0;
                    end
                    REG_LENGTH: length <= s_writedata[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        s_readdata = '0;
        if (s_address >= REG_STEP_BASE) begin
            s_readdata = steps[s_address[IDX_W-1:0]];
        end else begin
            case (s_address)
                REG_CTRL:   s_readdata[1:0] = {loop_en, run};
                REG_STATUS: begin
                    s_readdata[0]          = (state != ST_IDLE);
                    s_readdata[1]          = done;
                    s_readdata[4 +: IDX_W] = index;
                end
                REG_LENGTH: s_readdata[3:0] = length;
                default:    s_readdata = '0;
            endcase
        end
    end

endmodule
